// File: rtl/move_list_serializer_if.sv
// ============================================================================
// Module      : move_list_serializer_if
// Description : Load / stream handshake bundle between the move generator,
//               the move_list_serializer and the move-ordering consumer.
//               The move_count signal exists only when MOVE_SER_COUNT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_list_serializer_if #(
  parameter int N_SQ = 64,
  parameter int SQ_W = $clog2(N_SQ)
);
  logic              start;
  logic [N_SQ-1:0]   mask_in;
  logic [SQ_W-1:0]   from_sq_in;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [SQ_W-1:0]   out_from;
  logic [SQ_W-1:0]   out_to;
  logic              out_last;
  logic              done;
`ifdef MOVE_SER_COUNT_EN
  logic [SQ_W:0]     move_count;

  // Generator / consumer side
  modport master (
    output start, mask_in, from_sq_in, out_ready,
    input  busy, out_valid, out_from, out_to, out_last, done, move_count
  );

  // Serializer side
  modport slave (
    input  start, mask_in, from_sq_in, out_ready,
    output busy, out_valid, out_from, out_to, out_last, done, move_count
  );
`else
  // Generator / consumer side
  modport master (
    output start, mask_in, from_sq_in, out_ready,
    input  busy, out_valid, out_from, out_to, out_last, done
  );

  // Serializer side
  modport slave (
    input  start, mask_in, from_sq_in, out_ready,
    output busy, out_valid, out_from, out_to, out_last, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/move_list_serializer.sv
// ============================================================================
// Module      : move_list_serializer
// Description : Captures a 64-bit legal-destination mask for one source square
//               and streams the set destinations as (from,to) moves over a
//               valid/ready handshake, lowest square index first, one move
//               per cycle when the consumer is always ready.
//               Optional feature macro: MOVE_SER_COUNT_EN adds move_count,
//               the popcount of the mask captured on the last accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_list_serializer #(
  parameter int N_SQ = 64,
  parameter int SQ_W = $clog2(N_SQ)
) (
  input  wire                    clk,
  input  wire                    reset_n,
  move_list_serializer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_SQ-1:0]   r_rem;
  logic [SQ_W-1:0]   r_from;
  logic [N_SQ-1:0]   w_rem_clr;
  logic [SQ_W-1:0]   w_low_idx;
  logic              w_one_left;
  logic              w_load;
  logic              w_pop;

  // Remaining mask with its lowest set bit removed; also tells whether only
  // one destination is left (clearing it leaves nothing).
  assign w_rem_clr  = r_rem & (r_rem - N_SQ'(1));
  assign w_one_left = (r_rem != '0) && (w_rem_clr == '0);

  // Priority encoder: index of lowest set bit of the registered remaining mask
  always_comb begin
    w_low_idx = '0;
    for (int i = N_SQ - 1; i >= 0; i--) begin
      if (r_rem[i]) begin
        w_low_idx = SQ_W'(i);
      end
    end
  end

  // Next-state logic and load/pop strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = (bus.mask_in != '0) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        if (bus.out_ready) begin
          w_pop = 1'b1;
          if (w_one_left) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, list capture and per-handshake bit clearing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_from  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_rem  <= bus.mask_in;
        r_from <= bus.from_sq_in;
      end else if (w_pop) begin
        r_rem  <= w_rem_clr;
      end
    end
  end

`ifdef MOVE_SER_COUNT_EN
  logic [SQ_W:0] w_pop_cnt;
  logic [SQ_W:0] r_move_count;

  // Population count of the incoming mask
  always_comb begin
    w_pop_cnt = '0;
    for (int i = 0; i < N_SQ; i++) begin
      w_pop_cnt = w_pop_cnt + {{SQ_W{1'b0}}, bus.mask_in[i]};
    end
  end

  // Move count is captured with the list and held until the next load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_move_count <= '0;
    end else if (w_load) begin
      r_move_count <= w_pop_cnt;
    end
  end

  assign bus.move_count = r_move_count;
`endif

  // All outputs decode registered state; out_ready only affects the next edge
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_SCAN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.out_from  = r_from;
  assign bus.out_to    = w_low_idx;
  assign bus.out_last  = (r_state == S_SCAN) && w_one_left;

endmodule

`default_nettype wire

// File: tb/tb_move_list_serializer.sv
// ============================================================================
// Module      : tb_move_list_serializer
// Description : Directed self-checking bench for move_list_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_list_serializer;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  move_list_serializer_if bus ();

  move_list_serializer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_list(input logic [5:0] from_sq, input logic [63:0] mask);
    bus.start      = 1'b1;
    bus.from_sq_in = from_sq;
    bus.mask_in    = mask;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.mask_in    = '0;
    bus.from_sq_in = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    check("rst_busy",  bus.busy,      0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last",  bus.out_last,  0);
    check("rst_done",  bus.done,      0);
    check("rst_from",  bus.out_from,  0);
    check("rst_to",    bus.out_to,    0);
`ifdef MOVE_SER_COUNT_EN
    check("rst_count", bus.move_count, 0);
`endif

    // 1: from 12, destinations {4,20,28}
    bus.out_ready = 1'b1;
    start_list(6'd12, (64'd1 << 20) | (64'd1 << 28) | (64'd1 << 4));
    check("t1_valid0", bus.out_valid, 1);
    check("t1_busy0",  bus.busy,      1);
    check("t1_from0",  bus.out_from,  12);
    check("t1_to0",    bus.out_to,    4);
    check("t1_last0",  bus.out_last,  0);
`ifdef MOVE_SER_COUNT_EN
    check("t1_count",  bus.move_count, 3);
`endif
    tick();
    check("t1_to1",    bus.out_to,    20);
    check("t1_last1",  bus.out_last,  0);
    tick();
    check("t1_to2",    bus.out_to,    28);
    check("t1_last2",  bus.out_last,  1);
    check("t1_from2",  bus.out_from,  12);
    tick();
    check("t1_dvalid", bus.out_valid, 0);
    check("t1_done",   bus.done,      1);
    check("t1_dbusy",  bus.busy,      1);
    tick();
    check("t1_done_end", bus.done,    0);
    check("t1_busy_end", bus.busy,    0);

    // 2: empty mask
    start_list(6'd3, 64'd0);
    check("t2_valid", bus.out_valid, 0);
    check("t2_done",  bus.done,      1);
    check("t2_busy",  bus.busy,      1);
    tick();
    check("t2_valid2", bus.out_valid, 0);
    check("t2_done2",  bus.done,      0);
    check("t2_busy2",  bus.busy,      0);

    // 3: full mask streams 0..63 back to back
    start_list(6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef MOVE_SER_COUNT_EN
    check("t3_count", bus.move_count, 64);
`endif
    for (int i = 0; i < 64; i++) begin
      check($sformatf("t3_valid%0d", i), bus.out_valid, 1);
      check($sformatf("t3_to%0d", i),    bus.out_to,    i);
      check($sformatf("t3_last%0d", i),  bus.out_last,  (i == 63) ? 1 : 0);
      tick();
    end
    check("t3_done",  bus.done,      1);
    check("t3_valid", bus.out_valid, 0);
    tick();

    // 4: stall for 5 cycles with extra starts while busy
    bus.out_ready = 1'b0;
    start_list(6'd33, (64'd1 << 1) | (64'd1 << 62));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_valid%0d", k), bus.out_valid, 1);
      check($sformatf("t4_hold_to%0d", k),    bus.out_to,    1);
      check($sformatf("t4_hold_last%0d", k),  bus.out_last,  0);
      check($sformatf("t4_hold_from%0d", k),  bus.out_from,  33);
      bus.start      = (k == 1) || (k == 3);
      bus.mask_in    = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.from_sq_in = 6'd5;
      if (k < 4) tick();
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t4_to62",   bus.out_to,   62);
    check("t4_last62", bus.out_last, 1);
    check("t4_from62", bus.out_from, 33);
    tick();
    check("t4_done", bus.done, 1);
    // start during the done cycle must be ignored
    bus.start   = 1'b1;
    bus.mask_in = 64'd1 << 7;
    tick();
    bus.start   = 1'b0;
    check("t4_ign_busy",  bus.busy,      0);
    check("t4_ign_valid", bus.out_valid, 0);

    // 5: reset mid-list, then a single-move list
    start_list(6'd50, 64'h3FF);
    check("t5_to0", bus.out_to, 0);
    tick();
    check("t5_to1", bus.out_to, 1);
    tick();
    check("t5_to2", bus.out_to, 2);
    tick();
    check("t5_to3", bus.out_to, 3);
    reset_n = 1'b0;
    tick();
    check("t5_rbusy",  bus.busy,      0);
    check("t5_rvalid", bus.out_valid, 0);
    check("t5_rdone",  bus.done,      0);
    check("t5_rfrom",  bus.out_from,  0);
    check("t5_rto",    bus.out_to,    0);
    check("t5_rlast",  bus.out_last,  0);
`ifdef MOVE_SER_COUNT_EN
    check("t5_rcount", bus.move_count, 0);
`endif
    reset_n = 1'b1;
    tick();
    check("t5_nodone", bus.done, 0);
    start_list(6'd9, 64'd1 << 7);
    check("t5_valid", bus.out_valid, 1);
    check("t5_to7",   bus.out_to,    7);
    check("t5_last7", bus.out_last,  1);
    check("t5_from9", bus.out_from,  9);
`ifdef MOVE_SER_COUNT_EN
    check("t5_count", bus.move_count, 1);
`endif
    tick();
    check("t5_done", bus.done, 1);
    tick();

    // 6: back-to-back lists, second start right after done
    start_list(6'd1, 64'd1 << 5);
    check("t6a_to5",   bus.out_to,   5);
    check("t6a_last5", bus.out_last, 1);
    tick();
    check("t6a_done", bus.done, 1);
    tick();
    start_list(6'd2, (64'd1 << 10) | (64'd1 << 11));
    check("t6b_valid",  bus.out_valid, 1);
    check("t6b_from",   bus.out_from,  2);
    check("t6b_to10",   bus.out_to,    10);
    check("t6b_last10", bus.out_last,  0);
    tick();
    check("t6b_to11",   bus.out_to,    11);
    check("t6b_last11", bus.out_last,  1);
    tick();
    check("t6b_done",   bus.done,      1);
    check("t6b_valid2", bus.out_valid, 0);
    tick();
    check("t6b_idle",   bus.busy,      0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
